// File: rtl/counter_down_load_pkg.sv
// Shared constants for the loadable down-counter: FSM state encoding and
// the one-shot / periodic mode values latched on load.
package counter_down_load_pkg;

    // FSM state encoding (kept as plain constants for legacy compatibility)
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Counting mode captured when load is asserted
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/ffd_en_ar.sv
// Parameterized D register with synchronous enable and asynchronous
// active-high reset to zero. Used as the storage element for the count
// and for the reload value/mode pair of the down-counter.
module ffd_en_ar #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d on enabled rising edges; clear immediately on arst
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/counter_down_load.sv
// Synchronous loadable down-counter/timer. Loads a start value, counts down
// on enabled edges while in RUN, and pulses tc for one clock after the
// terminal step. In periodic mode the start value is reloaded at terminal
// count; in one-shot mode the counter parks in DONE at zero.
module counter_down_load #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         mode,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         running
);

    import counter_down_load_pkg::*;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   state_q;
    logic [1:0]   state_d;
    logic         tc_d;
    logic [N-1:0] count_d;
    logic         count_we;
    logic [N:0]   cfg_d;
    logic [N:0]   cfg_q;
    logic [N-1:0] reload_q;
    logic         mode_q;

    assign cfg_d    = {mode, d};
    assign reload_q = cfg_q[N-1:0];
    assign mode_q   = cfg_q[N];

    // Count register: written on load or on an enabled step in RUN
    ffd_en_ar #(.W(N)) u_count (
        .clk  (clk),
        .arst (arst),
        .en   (count_we),
        .d    (count_d),
        .q    (count)
    );

    // Reload value and mode are captured together, only on load
    ffd_en_ar #(.W(N + 1)) u_cfg (
        .clk  (clk),
        .arst (arst),
        .en   (load),
        .d    (cfg_d),
        .q    (cfg_q)
    );

    // Next-state, decrement and terminal-count decode; load overrides all
    always_comb begin
        state_d  = state_q;
        tc_d     = 1'b0;
        count_d  = count;
        count_we = 1'b0;
        if (load) begin
            count_d  = d;
            count_we = 1'b1;
            state_d  = (d != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (en && (count != '0)) begin
                        count_we = 1'b1;
                        if (count == ONE) begin
                            tc_d = 1'b1;
                            if (mode_q == MODE_PERIODIC) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end
                        end else begin
                            count_d = count - ONE;
                        end
                    end
                end
                ST_IDLE: state_d = ST_IDLE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and terminal-count pulse registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            tc      <= 1'b0;
        end else begin
            state_q <= state_d;
            tc      <= tc_d;
        end
    end

    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_down_load.sv
// Directed self-checking bench for counter_down_load at N=4.
module tb_counter_down_load;

    logic       clk;
    logic       arst;
    logic       en;
    logic       load;
    logic [3:0] d;
    logic       mode;
    logic [3:0] count;
    logic       tc;
    logic       running;

    int assert_count = 0;
    int fail_count   = 0;

    counter_down_load #(.N(4)) dut (
        .clk     (clk),
        .arst    (arst),
        .en      (en),
        .load    (load),
        .d       (d),
        .mode    (mode),
        .count   (count),
        .tc      (tc),
        .running (running)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and tally
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive inputs, take one rising edge, and settle 1 unit after it
    task automatic applyStimulus(input logic ld, input logic [3:0] dv,
                                 input logic md, input logic e);
        load = ld;
        d    = dv;
        mode = md;
        en   = e;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Check all three outputs at once
    task automatic checkAll(input string tag, input logic [3:0] c,
                            input logic t, input logic r);
        checkOutput({tag, ".count"}, 32'(count), 32'(c));
        checkOutput({tag, ".tc"}, 32'(tc), 32'(t));
        checkOutput({tag, ".running"}, 32'(running), 32'(r));
    endtask

    logic [3:0] per_cnt [12] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd3, 4'd3,
                                 4'd2, 4'd2, 4'd1, 4'd1, 4'd3, 4'd3};
    logic       per_tc  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] one_cnt [5]  = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    logic       one_tc  [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        arst = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        d    = 4'd0;
        mode = 1'b0;
        #1;
        checkAll("reset", 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        arst = 1'b0;
        @(negedge clk);

        // Reset mid-count
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
        checkAll("mid_load", 4'd9, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkAll("mid_run", 4'd6, 1'b0, 1'b1);
        #1 arst = 1'b1;
        #1 checkAll("mid_arst", 4'd0, 1'b0, 1'b0);
        #1 arst = 1'b0;
        @(negedge clk);

        // One-shot 5 down to 0, then parked in DONE
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b1);
        checkAll("os_load", 4'd5, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
            checkOutput($sformatf("os_step%0d.count", i), 32'(count), 32'(one_cnt[i]));
            checkOutput($sformatf("os_step%0d.tc", i), 32'(tc), 32'(one_tc[i]));
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
            checkAll($sformatf("os_done%0d", i), 4'd0, 1'b0, 1'b0);
        end

        // Periodic reload 3 with gapped enable; mode input changes are ignored
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0);
        checkAll("per_load", 4'd3, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b0, ((i % 2) == 0));
            checkAll($sformatf("per%0d", i), per_cnt[i], per_tc[i], 1'b1);
        end

        // Load wins over the terminal step
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkAll("prio_pre", 4'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd12, 1'b0, 1'b1);
        checkAll("prio_load", 4'd12, 1'b0, 1'b1);

        // Zero load parks in IDLE with en ignored
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
        checkAll("zero_load", 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkAll("zero_hold", 4'd0, 1'b0, 1'b0);

        // Maximum load: tc exactly 15 edges after load
        applyStimulus(1'b1, 4'd15, 1'b0, 1'b1);
        checkAll("max_load", 4'd15, 1'b0, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
            checkOutput($sformatf("max_step%0d.count", i), 32'(count), 32'(15 - i));
            checkOutput($sformatf("max_step%0d.tc", i), 32'(tc), 32'(0));
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkAll("max_tc", 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkAll("max_after", 4'd0, 1'b0, 1'b0);

        // Reload of 1 in periodic mode: tc every enabled edge
        applyStimulus(1'b1, 4'd1, 1'b1, 1'b1);
        checkAll("r1_load", 4'd1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
            checkAll($sformatf("r1_%0d", i), 4'd1, 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
